// File: rtl/page_alloc_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : page_alloc_arb_if
// Description : Request/grant and page-release bundle for page_alloc_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface page_alloc_arb_if;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [4:0]  gnt_page;
    logic        rls_vld;
    logic [4:0]  rls_page;
    logic [5:0]  free_cnt;
    logic        init_done;
    logic [15:0] fail_cnt;

    modport master (
        output req, rls_vld, rls_page,
        input  gnt, gnt_page, free_cnt, init_done, fail_cnt
    );

    modport slave (
        input  req, rls_vld, rls_page,
        output gnt, gnt_page, free_cnt, init_done, fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/page_alloc_arb.sv
`default_nettype none
// ============================================================================
// Module      : page_alloc_arb
// Description : 32-page free-list allocator with 4-port round-robin grant.
//               Optional macro PAGE_ALLOC_STAT_EN enables the fail_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
module page_alloc_arb (
    input  wire logic       sys_clk,
    input  wire logic       sys_rst_n,
    page_alloc_arb_if.slave bus
);
    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;
    localparam logic [5:0] c_pages   = 6'd32;

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic [4:0] r_rd_ptr;
    logic [4:0] r_wr_ptr;
    logic [5:0] r_free_cnt;
    logic [1:0] r_last;
    logic [3:0] r_gnt;
    logic [4:0] r_gnt_page;
    logic [4:0] r_mem [32];

    logic       w_run;
    logic       w_init_wr;
    logic       w_init_last;
    logic [3:0] w_elig;
    logic       w_found;
    logic [1:0] w_gnt_idx;
    logic [1:0] w_cand;
    logic       w_do_gnt;
    logic       w_do_push;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: INIT lasts until the last page has been written
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_init: if (w_init_last) w_next_state = c_st_run;
            default:   w_next_state = c_st_run;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_run         = (r_state == c_st_run);
        w_init_wr     = (r_state == c_st_init);
        w_init_last   = w_init_wr && (r_wr_ptr == 5'd31);
        bus.init_done = w_run;
    end

    // The port granted last cycle still holds req while it sees gnt
    assign w_elig = bus.req & ~r_gnt;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = r_last;
        w_cand    = r_last;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last + 2'(i);
            if (!w_found && w_elig[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_do_gnt  = w_run && w_found && (r_free_cnt != 6'd0);
    assign w_do_push = w_run && bus.rls_vld && (r_free_cnt != c_pages);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gnt      <= 4'b0000;
            r_gnt_page <= 5'd0;
            r_rd_ptr   <= 5'd0;
            r_wr_ptr   <= 5'd0;
            r_free_cnt <= 6'd0;
            r_last     <= 2'd3;
        end else begin
            r_gnt <= w_do_gnt ? (4'b0001 << w_gnt_idx) : 4'b0000;
            if (w_do_gnt) begin
                r_gnt_page <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 5'd1;
                r_last     <= w_gnt_idx;
            end
            if (w_init_wr || w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 5'd1;
            end
            if (w_init_last) begin
                r_free_cnt <= c_pages;
            end else begin
                case ({w_do_push, w_do_gnt})
                    2'b10:   r_free_cnt <= r_free_cnt + 6'd1;
                    2'b01:   r_free_cnt <= r_free_cnt - 6'd1;
                    default: r_free_cnt <= r_free_cnt;
                endcase
            end
        end
    end

    // List storage needs no reset: INIT rewrites every entry
    always_ff @(posedge sys_clk) begin
        if (w_init_wr) begin
            r_mem[r_wr_ptr] <= r_wr_ptr;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= bus.rls_page;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.gnt_page = r_gnt_page;
    assign bus.free_cnt = r_free_cnt;

`ifdef PAGE_ALLOC_STAT_EN
    logic [15:0] r_fail_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fail_cnt <= 16'd0;
        end else if (w_run && (bus.req != 4'b0000) && (r_free_cnt == 6'd0)
                     && (r_fail_cnt != 16'hFFFF)) begin
            r_fail_cnt <= r_fail_cnt + 16'd1;
        end
    end

    assign bus.fail_cnt = r_fail_cnt;
`else
    assign bus.fail_cnt = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_page_alloc_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_page_alloc_arb
// Description : Randomized and directed bench for page_alloc_arb against a
//               queue-based free-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_page_alloc_arb;
    logic sys_clk;
    logic sys_rst_n;

    page_alloc_arb_if bus ();

    page_alloc_arb u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: free list as a queue of page numbers
    int unsigned m_q[$];
    logic [3:0]  m_gnt;
    int          m_page;
    int          m_last;
    int          m_fail;
    int          m_init_left;

    task automatic model_reset();
        m_q.delete();
        m_gnt       = 4'b0000;
        m_page      = 0;
        m_last      = 3;
        m_fail      = 0;
        m_init_left = 32;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rv, input logic [4:0] rp);
        int         size0;
        logic [3:0] elig;
        logic [3:0] g;
        int         p;
        g = 4'b0000;
        if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) begin
                for (int k = 0; k < 32; k++) m_q.push_back(k);
            end
        end else begin
            size0 = m_q.size();
            elig  = r & ~m_gnt;
            if (elig != 4'b0000 && size0 > 0) begin
                for (int i = 1; i <= 4; i++) begin
                    p = (m_last + i) % 4;
                    if (g == 4'b0000 && elig[p]) g[p] = 1'b1;
                end
                for (int k = 0; k < 4; k++) if (g[k]) m_last = k;
                m_page = m_q.pop_front();
            end
            if (rv && size0 < 32) m_q.push_back(rp);
`ifdef PAGE_ALLOC_STAT_EN
            if (r != 4'b0000 && size0 == 0 && m_fail < 65535) m_fail++;
`endif
        end
        m_gnt = g;
    endtask

    task automatic compare_outputs();
        check("gnt", 32'(bus.gnt), 32'(m_gnt));
        if (m_gnt != 4'b0000) check("gnt_page", 32'(bus.gnt_page), 32'(m_page));
        check("free_cnt", 32'(bus.free_cnt), 32'(m_q.size()));
        check("init_done", 32'(bus.init_done), 32'(m_init_left == 0));
        check("fail_cnt", 32'(bus.fail_cnt), 32'(m_fail));
    endtask

    task automatic run_cycle(input logic [3:0] r, input logic rv, input logic [4:0] rp);
        bus.req      = r;
        bus.rls_vld  = rv;
        bus.rls_page = rp;
        model_step(r, rv, rp);
        @(negedge sys_clk);
        compare_outputs();
    endtask

    // Requester behaviour: hold req until granted, keep it the gnt cycle, then drop
    logic [3:0] req_st;
    logic [3:0] drop_pend;

    task automatic step_proto(input logic [3:0] raise_mask, input int prob,
                              input logic rv, input logic [4:0] rp);
        for (int p = 0; p < 4; p++) begin
            if (drop_pend[p]) begin
                req_st[p]    = 1'b0;
                drop_pend[p] = 1'b0;
            end else if (m_gnt[p]) begin
                drop_pend[p] = 1'b1;
            end else if (!req_st[p] && raise_mask[p] && ($urandom_range(99) < prob)) begin
                req_st[p] = 1'b1;
            end
        end
        run_cycle(req_st, rv, rp);
    endtask

    task automatic async_reset();
        #2;
        sys_rst_n    = 1'b0;
        bus.req      = 4'b0000;
        bus.rls_vld  = 1'b0;
        bus.rls_page = 5'd0;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_free_cnt", 32'(bus.free_cnt), 32'h0);
        check("rst_init_done", 32'(bus.init_done), 32'h0);
        check("rst_fail_cnt", 32'(bus.fail_cnt), 32'h0);
        model_reset();
        req_st    = 4'b0000;
        drop_pend = 4'b0000;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        logic [4:0] pg;
        sys_rst_n    = 1'b0;
        bus.req      = 4'b0000;
        bus.rls_vld  = 1'b0;
        bus.rls_page = 5'd0;
        req_st       = 4'b0000;
        drop_pend    = 4'b0000;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        async_reset();

        // Init: 32 cycles with idle inputs, then release while full
        for (int i = 0; i < 32; i++) run_cycle(4'b0000, 1'b0, 5'd0);
        run_cycle(4'b0000, 1'b1, 5'd9);
        check("full_drop_free_cnt", 32'(bus.free_cnt), 32'd32);

        // All four ports request once: 0001,0010,0100,1000 with pages 0..3
        req_st = 4'b1111;
        run_cycle(req_st, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) step_proto(4'b0000, 0, 1'b0, 5'd0);
        check("four_grants_free_cnt", 32'(bus.free_cnt), 32'd28);

        // Drain the list with steady requests; pages must follow 4..31
        guard = 0;
        while (m_q.size() > 0 && guard < 300) begin
            step_proto(4'b1111, 100, 1'b0, 5'd0);
            guard++;
        end
        check("drain_done", 32'(m_q.size() == 0 && guard < 300), 32'd1);
        run_cycle(4'b0000, 1'b0, 5'd0);
        run_cycle(4'b0000, 1'b0, 5'd0);

        // Starved requester, then a release becomes grantable
        for (int i = 0; i < 10; i++) run_cycle(4'b0001, 1'b0, 5'd0);
        run_cycle(4'b0001, 1'b1, 5'd7);
        run_cycle(4'b0001, 1'b0, 5'd0);
        check("starve_gnt", 32'(bus.gnt), 32'h1);
        check("starve_page", 32'(bus.gnt_page), 32'd7);
        run_cycle(4'b0001, 1'b0, 5'd0);
        run_cycle(4'b0000, 1'b0, 5'd0);

        // Refill to 20, then simultaneous grant and release
        pg = 5'd10;
        guard = 0;
        while (m_q.size() < 20 && guard < 64) begin
            run_cycle(4'b0000, 1'b1, pg);
            pg = pg + 5'd1;
            guard++;
        end
        run_cycle(4'b0100, 1'b1, 5'd5);
        check("simul_gnt", 32'(bus.gnt), 32'h4);
        check("simul_free_cnt", 32'(bus.free_cnt), 32'd20);
        run_cycle(4'b0100, 1'b0, 5'd0);
        run_cycle(4'b0000, 1'b0, 5'd0);

        // Randomized traffic
        req_st    = 4'b0000;
        drop_pend = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0)
                step_proto(4'b1111, $urandom_range(100), 1'b1, 5'($urandom_range(31)));
            else
                step_proto(4'b1111, $urandom_range(100), 1'b0, 5'd0);
        end

        // Reset in the middle of heavy traffic
        async_reset();
        for (int i = 0; i < 40; i++) step_proto(4'b1111, 100, 1'b0, 5'd0);
        async_reset();
        for (int i = 0; i < 32; i++) run_cycle(4'b1111, 1'b0, 5'd0);
        req_st = 4'b1111;
        run_cycle(req_st, 1'b0, 5'd0);
        check("post_rst_gnt", 32'(bus.gnt), 32'h1);
        check("post_rst_page", 32'(bus.gnt_page), 32'd0);
        for (int i = 0; i < 200; i++)
            step_proto(4'b1111, 60, $urandom_range(1) == 1, 5'($urandom_range(31)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/page_alloc_arb.md
PAGE_ALLOC_ARB -- requirements
Module: page_alloc_arb

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: sys_clk is the single clock and sys_rst_n is the reset, asserted at 0 and acting without waiting for a clock edge.
REQ-002 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst_n  in  1  asynchronous active-low reset.
REQ-004 req  in  4  per-ingress-port page request, level; raised at page start (page_fr).
REQ-005 gnt  out  4  one-hot grant pulse, registered, one cycle wide.
REQ-006 gnt_page  out  5  page address accompanying gnt; valid only when gnt!=0.
REQ-007 rls_vld  in  1  page release strobe from egress.
REQ-008 rls_page  in  5  page address released, sampled when rls_vld=1.
REQ-009 free_cnt  out  6  number of pages in free list, 0..32.
REQ-010 init_done  out  1  1 once free list is populated.
REQ-011 fail_cnt  out  16  allocation-starvation counter (see Configuration).

Function
REQ-012 Free list SHALL be a 32-entry circular FIFO of 5-bit page addresses with 5-bit rd/wr pointers wrapping 31->0.
REQ-013 FSM SHALL have states INIT and RUN; reset enters INIT.
REQ-014 INIT: write page k to entry k for k=0..31, one per cycle; after 32 cycles move to RUN, free_cnt=32, init_done=1.
REQ-015 In INIT, req and rls_vld SHALL be ignored and gnt held 0.
REQ-016 RUN: in a cycle with any eligible req and free_cnt>0, grant exactly one requester; gnt and gnt_page appear the following cycle (1-cycle latency); pop one entry.
REQ-017 Selection SHALL be round-robin: search starts at port (last_granted+1) mod 4; last_granted resets to 3 so port 0 wins first.
REQ-018 Requester granted in the previous cycle SHALL be masked for one cycle (requester drops req the cycle after gnt); no port receives back-to-back grants from one request.
REQ-019 Arbitration SHALL sustain one grant per cycle when requests and pages are available.
REQ-020 rls_vld in RUN with free_cnt<32 SHALL push rls_page at wr pointer.
REQ-021 rls_vld with free_cnt=32 SHALL be dropped; free_cnt unchanged.
REQ-022 Simultaneous grant and release SHALL both occur; free_cnt unchanged.
REQ-023 free_cnt=0 with release: released page not bypassed; grantable the next cycle.
REQ-024 free_cnt=0 with requests: no grant, req stays pending, rr pointer unchanged.
REQ-025 free_cnt SHALL never wrap below 0 or above 32.

Reset
REQ-026 On sys_rst_n=0: gnt=0, gnt_page=0, free_cnt=0, init_done=0, fail_cnt=0, pointers=0, last_granted=3, state=INIT.
REQ-027 Reset mid-operation SHALL discard all outstanding grants and list contents and restart INIT after release.

Configuration
REQ-028 Macro PAGE_ALLOC_STAT_EN: when defined, fail_cnt increments by 1 each RUN cycle with req!=0 and free_cnt=0, saturating at 16'hFFFF.
REQ-029 Without PAGE_ALLOC_STAT_EN, fail_cnt SHALL be constant 0 and counter logic omitted; all other behaviour identical.

Verification
REQ-030 Reset release, req=4'b0000 -> init_done=1 and free_cnt=32 exactly 32 cycles later; gnt stays 0 throughout.
REQ-031 After init, req=4'b1111 held with drop-after-grant -> gnt sequence 0001,0010,0100,1000 on consecutive cycles, gnt_page 0,1,2,3, free_cnt 28.
REQ-032 Drain 32 pages, then req=4'b0001 -> no gnt; with PAGE_ALLOC_STAT_EN fail_cnt counts 10 after 10 cycles; rls_vld with rls_page=7 -> next cycle gnt=0001, gnt_page=7.
REQ-033 free_cnt=20, req=4'b0100 and rls_vld (rls_page=5) same cycle -> gnt=0100 next cycle, free_cnt stays 20.
REQ-034 free_cnt=32, rls_vld with rls_page=9 -> free_cnt stays 32, no list corruption (next 32 grants return 0..31 order).
REQ-035 sys_rst_n pulsed low while req=4'b1111 active -> gnt=0 immediately, INIT re-runs 32 cycles, first grant afterwards gnt_page=0 to port 0.
